fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined ARM core. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses. It buffers returned words with their PCs in a small FIFO and presents `InstrD`/`PCPlus8D` to decode, which feeds `InstrD[23:0]` to the immediate extender. Taken branches from Execute redirect the PC and squash wrong-path fetches.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg : shared constants and fetch-buffer entry type          |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package core_pkg;
  localparam int          INSTR_W        = 32;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo : shifting FIFO of {instr, pc}; entry 0 is the head   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_fifo
  import core_pkg::*;
#(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RST_ENTRY = '0,
  localparam int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       din,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t       entries_q [DEPTH];
  fetch_entry_t       entries_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   wr_pos;

  // A popped slot shifts down first, so a simultaneous push lands one lower.
  assign wr_pos = count_q - CNT_W'(pop);

  always_comb begin
    entries_d = entries_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        entries_d[i] = entries_q[i+1];
      end
    end
    if (push) begin
      entries_d[wr_pos[PTR_W-1:0]] = din;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= RST_ENTRY;
      end
    end else begin
      count_q <= count_d;
      if (!clr) begin
        entries_q <= entries_d;
      end
    end
  end

  assign head  = entries_q[0];
  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage : PC, credit-based imem requests, branch squash      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ImemReq,
  output logic [31:0]        ImemAddr,
  input  logic               ImemReady,
  input  logic               ImemRvalid,
  input  logic [INSTR_W-1:0] ImemRdata,
  input  logic               BranchTakenE,
  input  logic [31:0]        BranchTargetE,
  input  logic               StallD,
  output logic               ValidD,
  output logic [INSTR_W-1:0] InstrD,
  output logic [31:0]        PCPlus8D
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pcf_q, pcf_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [1:0]       inflight_q, inflight_d;
  logic [1:0]       discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head;
  logic             pop, fifo_pop, resp_keep, accept;
  logic [7:0]       credit;

  assign ValidD    = (fifo_count != '0);
  assign pop       = ValidD && !StallD;
  assign fifo_pop  = pop && !BranchTakenE;
  assign resp_keep = ImemRvalid && (discard_q == 2'd0) && !BranchTakenE;
  assign accept    = ImemReq && ImemReady;

  // Occupancy after this cycle's pop plus every good word still owed by memory.
  assign credit  = 8'(fifo_count) - 8'(pop) + 8'(inflight_q) - 8'(discard_q);
  assign ImemReq = !reset && !BranchTakenE && (inflight_q != 2'd3) && (credit < 8'(DEPTH));
  assign ImemAddr = {pcf_q[31:2], 2'b00};

  always_comb begin
    pcf_d      = pcf_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + 2'(accept) - 2'(ImemRvalid);
    discard_d  = discard_q;
    if (BranchTakenE) begin
      pcf_d     = BranchTargetE;
      resp_pc_d = BranchTargetE;
      discard_d = inflight_q - 2'(ImemRvalid);
    end else begin
      if (accept) begin
        pcf_d = pcf_q + PC_STEP;
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end
      if (ImemRvalid && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q      <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
    end else begin
      pcf_q      <= pcf_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .RST_ENTRY (fetch_entry_t'{instr: '0, pc: RESET_PC})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (BranchTakenE),
    .push  (resp_keep),
    .pop   (fifo_pop),
    .din   (fetch_entry_t'{instr: ImemRdata, pc: resp_pc_q}),
    .head  (head),
    .count (fifo_count)
  );

  assign InstrD   = head.instr;
  assign PCPlus8D = head.pc + PC_READ_OFFSET;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_stage : directed bench with an in-order memory model    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1, rst2 = 1'b1;
  logic        ImemReq, ImemReady = 1'b1, ImemRvalid = 1'b0;
  logic [31:0] ImemAddr, ImemRdata = '0;
  logic        BranchTakenE = 1'b0, StallD = 1'b0;
  logic [31:0] BranchTargetE = '0;
  logic        ValidD;
  logic [31:0] InstrD, PCPlus8D;
  logic        ImemReq2, ImemRvalid2 = 1'b0, ValidD2;
  logic [31:0] ImemAddr2, ImemRdata2 = '0, InstrD2, PCPlus8D2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE), .StallD(StallD),
    .ValidD(ValidD), .InstrD(InstrD), .PCPlus8D(PCPlus8D)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .reset(rst2), .ImemReq(ImemReq2), .ImemAddr(ImemAddr2),
    .ImemReady(1'b1), .ImemRvalid(ImemRvalid2), .ImemRdata(ImemRdata2),
    .BranchTakenE(1'b0), .BranchTargetE(32'h0), .StallD(1'b0),
    .ValidD(ValidD2), .InstrD(InstrD2), .PCPlus8D(PCPlus8D2)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc, lat, n_vec, n_err;
  bit          toggle_ready;
  logic        pend2;
  logic [31:0] paddr2, exp_pc, held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Present this cycle's memory responses, then let combinational outputs settle.
  task automatic drive();
    ImemRvalid = 1'b0;
    ImemRdata  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      ImemRvalid = 1'b1;
      ImemRdata  = mem_word(mq[0].addr);
    end
    ImemReady   = toggle_ready ? (cyc % 2 == 0) : 1'b1;
    ImemRvalid2 = pend2;
    ImemRdata2  = pend2 ? mem_word(paddr2) : '0;
    #1;
  endtask

  task automatic advance();
    if (ImemRvalid) void'(mq.pop_front());
    if (ImemReq && ImemReady) mq.push_back('{addr: ImemAddr, due: cyc + lat});
    pend2  = ImemReq2;
    paddr2 = ImemAddr2;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int latency, input bit tog);
    reset = 1'b1;
    BranchTakenE = 1'b0;
    StallD = 1'b0;
    mq.delete();
    ImemRvalid = 1'b0;
    lat = latency;
    toggle_ready = tog;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  logic        t_req  [14] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
  logic [31:0] t_addr [14] = '{32'h0, 32'h4, 0, 0, 32'h8, 32'hC, 0, 32'h100, 32'h104, 0, 0, 32'h108, 32'h10C, 0};
  logic        t_val  [14] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
  logic [31:0] t_pc8  [14] = '{0, 0, 0, 0, 32'h8, 32'hC, 0, 0, 0, 0, 0, 32'h108, 32'h10C, 0};

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 1; toggle_ready = 0; pend2 = 0; paddr2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(ImemReq), 0);
    chk("rst_valid", 32'(ValidD), 0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pc8", PCPlus8D, 32'h8);
    chk("rst_pc8_wrapcfg", PCPlus8D2, 32'h0);

    // Back-to-back stream, 1-cycle memory.
    do_reset(1, 0);
    for (int c = 0; c < 8; c++) begin
      drive();
      chk("s_req", 32'(ImemReq), 1);
      chk("s_addr", ImemAddr, 32'(4 * c));
      chk("s_valid", 32'(ValidD), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("s_pc8", PCPlus8D, 32'(8 + 4 * (c - 2)));
        chk("s_instr", InstrD, mem_word(32'(4 * (c - 2))));
      end
      advance();
    end

    // Stall 5 cycles mid-stream, then 8 more free-running cycles.
    exp_pc = 32'd24;
    held = '0;
    for (int c = 0; c < 13; c++) begin
      StallD = (c < 5);
      drive();
      chk("st_valid", 32'(ValidD), 1);
      chk("st_pc8", PCPlus8D, exp_pc + 32'd8);
      chk("st_instr", InstrD, mem_word(exp_pc));
      if (c > 0 && c < 5) chk("st_hold", InstrD, held);
      chk("st_occ", 32'(dut.fifo_count <= 2), 1);
      held = InstrD;
      if (!StallD) exp_pc += 32'd4;
      advance();
    end
    StallD = 1'b0;

    // Redirect coinciding with a response and a pop.
    do_reset(1, 0);
    for (int c = 0; c < 4; c++) begin drive(); advance(); end
    BranchTargetE = 32'h100;
    BranchTakenE = 1'b1;
    drive();
    chk("rp_valid", 32'(ValidD), 1);
    chk("rp_pc8", PCPlus8D, 32'h10);
    chk("rp_rvalid", 32'(ImemRvalid), 1);
    chk("rp_req_forced", 32'(ImemReq), 0);
    advance();
    BranchTakenE = 1'b0;
    drive();
    chk("rp_t1_valid", 32'(ValidD), 0);
    chk("rp_t1_count", 32'(dut.fifo_count), 0);
    chk("rp_t1_discard", 32'(dut.discard_q), 0);
    chk("rp_t1_addr", ImemAddr, 32'h100);
    chk("rp_t1_req", 32'(ImemReq), 1);
    advance();
    drive();
    chk("rp_t2_valid", 32'(ValidD), 0);
    chk("rp_t2_addr", ImemAddr, 32'h104);
    advance();
    drive();
    chk("rp_t3_valid", 32'(ValidD), 1);
    chk("rp_t3_pc8", PCPlus8D, 32'h108);
    chk("rp_t3_instr", InstrD, mem_word(32'h100));
    advance();
    drive();
    chk("rp_t4_pc8", PCPlus8D, 32'h10C);
    advance();

    // 3-cycle memory, redirect to 0x100 with two requests in flight.
    do_reset(3, 0);
    BranchTargetE = 32'h100;
    for (int c = 0; c < 14; c++) begin
      BranchTakenE = (c == 6);
      drive();
      chk("br_req", 32'(ImemReq), 32'(t_req[c]));
      if (t_req[c]) chk("br_addr", ImemAddr, t_addr[c]);
      chk("br_valid", 32'(ValidD), 32'(t_val[c]));
      if (t_val[c]) begin
        chk("br_pc8", PCPlus8D, t_pc8[c]);
        chk("br_instr", InstrD, mem_word(t_pc8[c] - 32'd8));
      end
      if (c == 6) chk("br_inflight", 32'(dut.inflight_q), 2);
      if (c == 7) chk("br_discard7", 32'(dut.discard_q), 2);
      if (c == 8) chk("br_discard8", 32'(dut.discard_q), 1);
      if (c == 9) chk("br_discard9", 32'(dut.discard_q), 0);
      advance();
    end
    BranchTakenE = 1'b0;

    // Toggling ready with 3-cycle memory: order, outstanding count, progress.
    do_reset(3, 1);
    exp_pc = 32'h0;
    for (int c = 0; c < 40; c++) begin
      drive();
      chk("tg_inflight", 32'(dut.inflight_q), 32'(mq.size()));
      if (ValidD) begin
        chk("tg_pc8", PCPlus8D, exp_pc + 32'd8);
        chk("tg_instr", InstrD, mem_word(exp_pc));
        exp_pc += 32'd4;
      end
      advance();
    end
    chk("tg_progress", 32'(exp_pc >= 32'd24), 1);

    // Address wrap from RESET_PC = FFFF_FFF8.
    pend2 = 1'b0;
    rst2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive();
      chk("wr_req", 32'(ImemReq2), 1);
      chk("wr_addr", ImemAddr2, 32'hFFFF_FFF8 + 32'(4 * c));
      chk("wr_valid", 32'(ValidD2), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("wr_pc8", PCPlus8D2, 32'(4 * (c - 2)));
        chk("wr_instr", InstrD2, mem_word(32'hFFFF_FFF8 + 32'(4 * (c - 2))));
      end
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
